// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart_tx_arbiter slice: FSM state encoding,
// the channel-id header marker and a ceiling-log2 helper for counter widths.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOAD,
        SEND,
        GAP
    } state_e;

    localparam int HDR_MARK = 'h80;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr, with
// wrap-around. The pointer register lives in the parent.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [clog2(N)-1:0]   ptr,
    output logic [N-1:0]          gnt,
    output logic [clog2(N)-1:0]   gnt_idx,
    output logic                  valid
);

    localparam int IW = clog2(N);

    logic [IW-1:0] idx;

    // NOTE: every output gets a default before the search loop so no latch is inferred.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        valid   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(ptr) + k) % N);
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-level round-robin sharing of one uart transmitter among NR_CH byte streams.
// Define UART_TX_ARBITER_CHANNEL_ID_EN to prefix each grant with a channel-id header byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NR_CH        = 4,
    parameter int NR_BITS      = 8,
    parameter int MAX_FRAME    = 256,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NR_CH*NR_BITS-1:0] req_d,
    input  logic [NR_CH-1:0]         req_dv,
    input  logic [NR_CH-1:0]         req_last,
    output logic [NR_CH-1:0]         req_dr,
    output logic [NR_BITS-1:0]       uart_tx_d,
    output logic                     uart_tx_dv,
    input  logic                     uart_tx_dr,
    output logic [NR_CH-1:0]         grant,
    output logic                     busy,
    output logic                     frame_trunc,
    output logic                     timeout
);

    localparam int CH_W  = clog2(NR_CH);
    localparam int CNT_W = clog2(MAX_FRAME + 1);
    localparam int STL_W = clog2(IDLE_TIMEOUT + 1);

    state_e               state_q, state_d;
    logic [CH_W-1:0]      ptr_q, ptr_d;
    logic [NR_CH-1:0]     grant_q, grant_d;
    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [STL_W-1:0]     stall_q, stall_d;
    logic [NR_BITS-1:0]   data_q, data_d;
    logic                 last_q, last_d;
    logic [NR_CH-1:0]     req_dr_q, req_dr_d;
    logic [NR_BITS-1:0]   tx_d_q, tx_d_d;
    logic                 tx_dv_q, tx_dv_d;
    logic                 trunc_q, trunc_d;
    logic                 timeout_q, timeout_d;

    logic [NR_CH-1:0]     arb_gnt;
    logic [CH_W-1:0]      arb_idx;
    logic                 arb_valid;

    rr_arbiter #(.N(NR_CH)) u_rr (
        .req     (req_dv),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .valid   (arb_valid)
    );

`ifdef UART_TX_ARBITER_CHANNEL_ID_EN
    logic [NR_BITS-1:0] hdr_byte;
    assign hdr_byte = NR_BITS'(HDR_MARK | int'(ptr_q));
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        stall_d   = stall_q;
        data_d    = data_q;
        last_d    = last_q;
        tx_d_d    = tx_d_q;
        req_dr_d  = '0;
        tx_dv_d   = 1'b0;
        trunc_d   = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_gnt;
                    busy_d  = 1'b1;
                    ptr_d   = arb_idx;
                    cnt_d   = '0;
                    stall_d = '0;
                    last_d  = 1'b0;
`ifdef UART_TX_ARBITER_CHANNEL_ID_EN
                    state_d = HDR;
`else
                    state_d = LOAD;
`endif
                end
            end
`ifdef UART_TX_ARBITER_CHANNEL_ID_EN
            HDR: begin
                // Header goes through GAP too, so uart spacing is identical to data.
                if (uart_tx_dr) begin
                    tx_d_d  = hdr_byte;
                    tx_dv_d = 1'b1;
                    state_d = GAP;
                end
            end
`endif
            LOAD: begin
                if (req_dv[ptr_q]) begin
                    data_d   = req_d[ptr_q*NR_BITS +: NR_BITS];
                    last_d   = req_last[ptr_q];
                    stall_d  = '0;
                    req_dr_d = grant_q;
                    state_d  = SEND;
                end else if (stall_q == STL_W'(IDLE_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                    stall_d   = '0;
                    state_d   = IDLE;
                end else begin
                    stall_d = stall_q + STL_W'(1);
                end
            end
            SEND: begin
                if (uart_tx_dr) begin
                    tx_d_d  = data_q;
                    tx_dv_d = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = GAP;
                end
            end
            GAP: begin
                // A byte flagged last wins over the MAX_FRAME limit: no truncation pulse.
                if (last_q || cnt_q == CNT_W'(MAX_FRAME)) begin
                    trunc_d = !last_q;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= CH_W'(NR_CH - 1);
            grant_q   <= '0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            stall_q   <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            req_dr_q  <= '0;
            tx_d_q    <= '0;
            tx_dv_q   <= 1'b0;
            trunc_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            stall_q   <= stall_d;
            data_q    <= data_d;
            last_q    <= last_d;
            req_dr_q  <= req_dr_d;
            tx_d_q    <= tx_d_d;
            tx_dv_q   <= tx_dv_d;
            trunc_q   <= trunc_d;
            timeout_q <= timeout_d;
        end
    end

    assign req_dr      = req_dr_q;
    assign uart_tx_d   = tx_d_q;
    assign uart_tx_dv  = tx_dv_q;
    assign grant       = grant_q;
    assign busy        = busy_q;
    assign frame_trunc = trunc_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed frames plus a randomized
// multi-channel run compared against a frame-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int NR_CH        = 4;
    localparam int NR_BITS      = 8;
    localparam int MAX_FRAME    = 4;
    localparam int IDLE_TIMEOUT = 16;
    localparam int BUDGET       = 4000;
`ifdef UART_TX_ARBITER_CHANNEL_ID_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NR_CH*NR_BITS-1:0] req_d;
    logic [NR_CH-1:0]         req_dv;
    logic [NR_CH-1:0]         req_last;
    logic [NR_CH-1:0]         req_dr;
    logic [NR_BITS-1:0]       uart_tx_d;
    logic                     uart_tx_dv;
    logic                     uart_tx_dr;
    logic [NR_CH-1:0]         grant;
    logic                     busy;
    logic                     frame_trunc;
    logic                     timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NR_CH(NR_CH), .NR_BITS(NR_BITS), .MAX_FRAME(MAX_FRAME), .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req_d(req_d), .req_dv(req_dv), .req_last(req_last),
        .req_dr(req_dr), .uart_tx_d(uart_tx_d), .uart_tx_dv(uart_tx_dv), .uart_tx_dr(uart_tx_dr),
        .grant(grant), .busy(busy), .frame_trunc(frame_trunc), .timeout(timeout)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Uart model: busy for uart_delay cycles after each load pulse.
    int ucnt = 0;
    int uart_delay = 10;
    always @(posedge clk) begin
        if (uart_tx_dv) ucnt <= uart_delay;
        else if (ucnt > 0) ucnt <= ucnt - 1;
    end
    assign uart_tx_dr = (ucnt == 0) && !uart_tx_dv;

    // Requesters: queue entry = data[7:0] | last<<8 | pre-gap cycles<<12.
    int                 chq [NR_CH][$];
    logic [NR_CH-1:0]   drv_act = '0;
    logic [NR_CH-1:0]   drv_last = '0;
    logic [NR_BITS-1:0] drv_d [NR_CH];
    int                 gap_cnt [NR_CH];

    assign req_dv   = drv_act;
    assign req_last = drv_last;
    for (genvar g = 0; g < NR_CH; g++) begin : g_drv
        assign req_d[g*NR_BITS +: NR_BITS] = drv_d[g];
    end

    always @(posedge clk) begin
        #2;
        for (int c = 0; c < NR_CH; c++) begin
            if (drv_act[c] && req_dr[c]) begin
                void'(chq[c].pop_front());
                drv_act[c] = 1'b0;
            end
            if (!drv_act[c] && chq[c].size() > 0) begin
                if (gap_cnt[c] < (chq[c][0] >> 12)) begin
                    gap_cnt[c]++;
                end else begin
                    gap_cnt[c]  = 0;
                    drv_d[c]    = NR_BITS'(chq[c][0]);
                    drv_last[c] = 1'((chq[c][0] >> 8) & 1);
                    drv_act[c]  = 1'b1;
                end
            end
        end
    end

    // Monitor: logs uart loads as (owner<<8 | byte), event cycles, req_dr counts.
    int obs_q[$], obs_cyc[$], exp_q[$], trunc_cyc[$], to_cyc[$];
    int dr_cnt [NR_CH];
    int rise_cyc [NR_CH];
    int cyc = 0;
    logic prev_dr = 1'b0, prev_dv = 1'b0;
    logic [NR_CH-1:0] prev_req_dv = '0;

    function automatic int onehot_idx(input logic [NR_CH-1:0] g);
        int n = 0;
        int r = 15;
        for (int i = 0; i < NR_CH; i++) if (g[i]) begin n++; r = i; end
        return (n == 1) ? r : 15;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (uart_tx_dv === 1'b1) begin
            check("uart_dv_after_ready", 32'(prev_dr), 1);
            check("uart_dv_spacing", 32'(prev_dv), 0);
            obs_q.push_back((onehot_idx(grant) << 8) | int'(uart_tx_d));
            obs_cyc.push_back(cyc);
        end
        for (int c = 0; c < NR_CH; c++) begin
            if (req_dr[c] === 1'b1) dr_cnt[c]++;
            if (req_dv[c] && !prev_req_dv[c]) rise_cyc[c] = cyc;
        end
        if (frame_trunc === 1'b1) trunc_cyc.push_back(cyc);
        if (timeout === 1'b1) to_cyc.push_back(cyc);
        prev_dr     = uart_tx_dr;
        prev_dv     = uart_tx_dv;
        prev_req_dv = req_dv;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        obs_q.delete(); obs_cyc.delete(); exp_q.delete(); trunc_cyc.delete(); to_cyc.delete();
        for (int c = 0; c < NR_CH; c++) dr_cnt[c] = 0;
    endtask

    task automatic push_req(input int c, input int data, input int last, input int gap);
        chq[c].push_back(data | (last << 8) | (gap << 12));
    endtask

    function automatic void exp_grant(input int c);
        if (HDR_EN) exp_q.push_back((c << 8) | (('h80 | c) & 'hFF));
    endfunction

    function automatic void exp_byte(input int c, input int b);
        exp_q.push_back((c << 8) | b);
    endfunction

    function automatic bit drivers_idle();
        for (int c = 0; c < NR_CH; c++) if (chq[c].size() > 0) return 1'b0;
        return drv_act == '0;
    endfunction

    task automatic wait_done(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            step();
            if (obs_q.size() >= exp_q.size() && drivers_idle() && busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_done"}, 32'(ok), 1);
        repeat (3) step();
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_byte"}, obs_q[i], exp_q[i]);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"}, 32'(grant), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_uart_dv"}, 32'(uart_tx_dv), 0);
        check({tag, "_req_dr"}, 32'(req_dr), 0);
    endtask

    // Frame-level reference: round robin over channels with pending bytes; each
    // grant runs until a last byte or MAX_FRAME bytes. Returns expected truncations.
    function automatic int run_model(ref int mq [NR_CH][$]);
        int ptr = NR_CH - 1;
        int ntr = 0;
        int c, cc, sent, e;
        bit done;
        for (int guard = 0; guard < 1000; guard++) begin
            c = -1;
            for (int off = 1; off <= NR_CH; off++) begin
                cc = (ptr + off) % NR_CH;
                if (c < 0 && mq[cc].size() > 0) c = cc;
            end
            if (c < 0) break;
            ptr = c;
            exp_grant(c);
            sent = 0;
            done = 1'b0;
            while (!done && mq[c].size() > 0) begin
                e = mq[c].pop_front();
                exp_byte(c, e & 'hFF);
                sent++;
                if (((e >> 8) & 1) == 1) done = 1'b1;
                else if (sent == MAX_FRAME) begin ntr++; done = 1'b1; end
            end
        end
        return ntr;
    endfunction

    int mq [NR_CH][$];
    int idx, val, len, data, exp_tr;
    bit found;

    initial begin
        for (int c = 0; c < NR_CH; c++) begin drv_d[c] = '0; gap_cnt[c] = 0; end

        // Reset values
        repeat (3) step();
        check_idle_outputs("reset");
        check("reset_trunc", 32'(frame_trunc), 0);
        check("reset_timeout", 32'(timeout), 0);
        check("reset_uart_d", 32'(uart_tx_d), 0);
        rst = 1'b0;
        repeat (2) step();
        check_idle_outputs("idle_no_req");

        // Single frame on ch1
        clear_logs();
        push_req(1, 'h41, 0, 0); push_req(1, 'h42, 0, 0); push_req(1, 'h43, 1, 0);
        exp_grant(1); exp_byte(1, 'h41); exp_byte(1, 'h42); exp_byte(1, 'h43);
        wait_done("single");
        compare_stream("single");
        val = (obs_cyc.size() > 0) ? obs_cyc[0] - rise_cyc[1] : -1;
        check("single_latency", val, 3);
        check("single_req_dr", dr_cnt[1], 3);
        check_idle_outputs("single_end");

        // Timeout: ch0 sends one byte without last, ch1 waits
        clear_logs();
        push_req(0, 'h10, 0, 0);
        push_req(1, 'h20, 1, 0);
        exp_grant(0); exp_byte(0, 'h10); exp_grant(1); exp_byte(1, 'h20);
        wait_done("timeout");
        compare_stream("timeout");
        check("timeout_pulses", to_cyc.size(), 1);
        idx = HDR_EN ? 1 : 0;
        val = (to_cyc.size() > 0 && obs_cyc.size() > idx) ? to_cyc[0] - obs_cyc[idx] : -1;
        check("timeout_delay", val, IDLE_TIMEOUT + 1);
        check("timeout_no_trunc", trunc_cyc.size(), 0);

        // Reset while ch2 is in SEND
        clear_logs();
        push_req(2, 'h31, 0, 0); push_req(2, 'h32, 1, 0);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (req_dr[2] === 1'b1) begin found = 1'b1; break; end
        end
        check("rst_reached_send", 32'(found), 1);
        rst = 1'b1;
        #1;
        check_idle_outputs("rst_async");
        for (int c = 0; c < NR_CH; c++) begin chq[c].delete(); gap_cnt[c] = 0; end
        drv_act = '0;
        repeat (3) begin
            step();
            check_idle_outputs("rst_hold");
        end
        rst = 1'b0;
        step();

        // Round robin after reset: ch0 first, then ch2, alternating per frame
        clear_logs();
        push_req(0, 'hA0, 0, 0); push_req(0, 'hA1, 1, 0); push_req(0, 'hA2, 0, 0); push_req(0, 'hA3, 1, 0);
        push_req(2, 'hC0, 0, 0); push_req(2, 'hC1, 1, 0); push_req(2, 'hC2, 0, 0); push_req(2, 'hC3, 1, 0);
        exp_grant(0); exp_byte(0, 'hA0); exp_byte(0, 'hA1);
        exp_grant(2); exp_byte(2, 'hC0); exp_byte(2, 'hC1);
        exp_grant(0); exp_byte(0, 'hA2); exp_byte(0, 'hA3);
        exp_grant(2); exp_byte(2, 'hC2); exp_byte(2, 'hC3);
        wait_done("rr");
        compare_stream("rr");

        // Truncation: ch3 sends 6 bytes with no last
        clear_logs();
        for (int k = 0; k < 6; k++) push_req(3, 'hD0 + k, 0, 0);
        exp_grant(3);
        for (int k = 0; k < 4; k++) exp_byte(3, 'hD0 + k);
        exp_grant(3);
        for (int k = 4; k < 6; k++) exp_byte(3, 'hD0 + k);
        wait_done("trunc");
        compare_stream("trunc");
        check("trunc_pulses", trunc_cyc.size(), 1);
        idx = HDR_EN ? 4 : 3;
        val = (trunc_cyc.size() > 0 && obs_cyc.size() > idx) ? trunc_cyc[0] - obs_cyc[idx] : -1;
        check("trunc_after_4th", val, 1);
        check("trunc_tail_timeout", to_cyc.size(), 1);

`ifdef UART_TX_ARBITER_CHANNEL_ID_EN
        // Header byte ahead of payload
        clear_logs();
        push_req(2, 'h55, 1, 0);
        exp_q.push_back((2 << 8) | 'h82);
        exp_q.push_back((2 << 8) | 'h55);
        wait_done("header");
        compare_stream("header");
`endif

        // Randomized: all channels loaded at once, compared with the frame-level model
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        clear_logs();
        uart_delay = $urandom_range(0, 3);
        for (int c = 0; c < NR_CH; c++) begin
            for (int f = 0; f < 3; f++) begin
                len = $urandom_range(1, 9);
                for (int k = 0; k < len; k++) begin
                    data = $urandom_range(0, 255);
                    push_req(c, data, (k == len - 1) ? 1 : 0,
                             (k % MAX_FRAME == 0) ? 0 : $urandom_range(0, 5));
                    mq[c].push_back(data | (((k == len - 1) ? 1 : 0) << 8));
                end
            end
        end
        exp_tr = run_model(mq);
        wait_done("random");
        compare_stream("random");
        check("random_trunc", trunc_cyc.size(), exp_tr);
        check("random_timeout", to_cyc.size(), 0);
        check_idle_outputs("random_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
